multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle sequencer for the shared-memory MIPS datapath. Replaces the single-cycle
//  decoder: one memory port serves fetch and data, with one ALU and Moore controls per state.
//  Covers R-type (ADD/ADDU/SUB/SUBU/AND/OR/SLT), LW, SW, BEQ, BNE, ADDI/ADDIU, ORI, LUI, J, JAL, JR.
//  Handles a variable-latency memory through a memrd/memwr -> memready handshake.
// PARAMETERS
//  ILLEGAL_HALT  1  1: an undefined op/funct goes to HALT. 0: it is treated as a NOP (back to FETCH).
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous reset, active-high
//  op          in   6  IR[31:26], stable outside FETCH
//  funct       in   6  IR[5:0]
//  zero        in   1  ALU zero flag, combinational from current ALU inputs
//  memready    in   1  memory completes the current access this cycle
//  memrd       out  1  memory read request (FETCH, MEMRD)
//  memwr       out  1  memory write request (MEMWR)
//  iord        out  1  0: address = pc; 1: address = aluout register
//  irwrite     out  1  load IR from memory read data
//  pcen        out  1  PC register enable
//  pcsrc       out  2  00 ALU result, 01 aluout reg, 10 {pc[31:28],instr[25:0],00}, 11 srca
//  alusrca     out  1  0: pc; 1: rs register A
//  alusrcb     out  2  00 rt B, 01 const 4, 10 ext imm (after shiftl16), 11 signimm<<2
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  signext     out  1  1: sign-extend imm16; 0: zero-extend
//  shiftl16    out  1  imm << 16 (LUI)
//  regwrite    out  1  register file write enable
//  regdst      out  1  0: rt; 1: rd
//  memtoreg    out  1  writeback = memory data register
//  isjal       out  1  write address forced to 31, write data = pc
//  halted      out  1  in HALT state
//  state       out  4  current state, for debug/bench
// BEHAVIOUR
//  - The state register is the only storage. All outputs are Moore decodes of state and op/funct, plus memready and zero where stated.
//  - While reset=1: state=FETCH. memrd, memwr, irwrite, pcen, regwrite and halted are all forced 0. Other outputs are don't-care.
//  - An unlisted control defaults to 0. regwrite, memwr, pcen and irwrite are never X.
//  - FETCH(0): memrd=1, iord=0, alusrca=0, alusrcb=01, alu add, pcsrc=00.
//      irwrite = pcen = memready. Stay in FETCH while !memready, else go to DECODE.
//  - DECODE(1): alusrca=0, alusrcb=11, add, signext=1. This precomputes the branch target into aluout.
//      Next state: LW/SW->MEMADR; R-type->EXEC; R-type with funct 001000->JR; BEQ/BNE->BRANCH;
//      ADDI/ADDIU/ORI/LUI->IMMEX; J/JAL->JUMP; anything else->HALT (or FETCH if ILLEGAL_HALT=0).
//  - MEMADR(2): alusrca=1, alusrcb=10, add, signext=1. Go to MEMRD for LW, MEMWR for SW.
//  - MEMRD(3): memrd=1, iord=1. Wait for memready, then go to MEMWB.
//  - MEMWB(4): regwrite=1, regdst=0, memtoreg=1. Go to FETCH.
//  - MEMWR(5): memwr=1, iord=1. Hold until memready, then go to FETCH. memwr stays high through the stall.
//  - EXEC(6): alusrca=1, alusrcb=00, alucontrol from funct. An undefined funct goes to HALT (or FETCH if ILLEGAL_HALT=0) instead of ALUWB.
//  - ALUWB(7): regwrite=1, regdst=1. Go to FETCH.
//  - BRANCH(8): alusrca=1, alusrcb=00, sub, pcsrc=01, pcen = zero ^ (op==BNE). Go to FETCH.
//  - IMMEX(9): alusrca=1, alusrcb=10.
//      ADDI/ADDIU: signext=1, add. ORI: signext=0, or. LUI: shiftl16=1, add.
//      The same controls are held in IMMWB.
//  - IMMWB(10): regwrite=1, regdst=0. Go to FETCH.
//  - JUMP(11): pcsrc=10, pcen=1. For JAL also regwrite=1 and isjal=1; pc already holds pc+4. Go to FETCH.
//  - JR(12): pcsrc=11, pcen=1. Go to FETCH.
//  - HALT(13): halted=1, all enables 0. Leave only by reset. Codes 14/15 go to HALT.
//  - Cycle counts with memready tied to 1:
//      R/ADDI-class/LW-addr: R=4, IMM=4, SW=4, LW=5, BEQ/BNE=3, J/JAL/JR=3.
//      Each extra memready=0 cycle adds one.
//  - Reset asserted mid-instruction aborts it at once. No partial write occurs after reset rises.
// TESTING
//  - Reset asserted mid-MEMWR -> memwr drops the same cycle. After release: state=0 and memrd=1 on the first clk.
//  - memready=1, op=000000, funct=100000 -> states 0,1,6,7,0. alucontrol=010 in EXEC. regwrite/regdst=1 only in ALUWB.
//  - LW with memready low 2 cycles in FETCH and 3 in MEMRD -> 10 cycles total. irwrite/pcen pulse once, on the memready cycle.
//  - BEQ with zero=1 -> pcen=1, pcsrc=01 in BRANCH. BNE with zero=1 -> pcen=0. BNE with zero=0 -> pcen=1.
//  - JAL -> in JUMP: pcen=1, pcsrc=10, regwrite=1, isjal=1. op=000000 + funct=001000 -> JR state, pcsrc=11.
//  - op=111111 -> HALT with halted=1 and no enables (ILLEGAL_HALT=1). With ILLEGAL_HALT=0 -> back to FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer: one state register, Moore control decodes per state,
// and a memrd/memwr -> memready handshake for a shared variable-latency memory.
module multicycle_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memrd,
  output logic       memwr,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       signext,
  output logic       shiftl16,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       isjal,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP   = 4'd11,
    S_JR     = 4'd12, S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000, OP_LW   = 6'b100011, OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI  = 6'b001101, OP_LUI  = 6'b001111;
  localparam logic [5:0] F_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001, ALU_SLT = 3'b111;

  // Where an undefined instruction ends up.
  localparam state_t S_BAD = ILLEGAL_HALT ? S_HALT : S_FETCH;

  // {defined, alucontrol} for an R-type funct.
  function automatic logic [3:0] funct_decode(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001: return {1'b1, ALU_ADD};
      6'b100010, 6'b100011: return {1'b1, ALU_SUB};
      6'b100100:            return {1'b1, ALU_AND};
      6'b100101:            return {1'b1, ALU_OR};
      6'b101010:            return {1'b1, ALU_SLT};
      default:              return 4'b0000;
    endcase
  endfunction

  state_t cur;
  logic [3:0] fdec;

  assign fdec  = funct_decode(funct);
  assign state = cur;

  // NOTE: state uses non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  if (memready) cur <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW:                      cur <= S_MEMADR;
            OP_R:                              cur <= (funct == F_JR) ? S_JR : S_EXEC;
            OP_BEQ, OP_BNE:                    cur <= S_BRANCH;
            OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: cur <= S_IMMEX;
            OP_J, OP_JAL:                      cur <= S_JUMP;
            default:                           cur <= S_BAD;
          endcase
        end
        S_MEMADR: cur <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (memready) cur <= S_MEMWB;
        S_MEMWR:  if (memready) cur <= S_FETCH;
        S_EXEC:   cur <= fdec[3] ? S_ALUWB : S_BAD;
        S_IMMEX:  cur <= S_IMMWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP, S_JR: cur <= S_FETCH;
        S_HALT:   cur <= S_HALT;
        default:  cur <= S_HALT;
      endcase
    end
  end

  // NOTE: every output is defaulted before the case so no latch can be inferred.
  always_comb begin
    memrd = 1'b0;  memwr = 1'b0;  iord = 1'b0;  irwrite = 1'b0;  pcen = 1'b0;
    pcsrc = 2'b00; alusrca = 1'b0; alusrcb = 2'b00; alucontrol = 3'b000;
    signext = 1'b0; shiftl16 = 1'b0; regwrite = 1'b0; regdst = 1'b0;
    memtoreg = 1'b0; isjal = 1'b0; halted = 1'b0;
    case (cur)
      S_FETCH: begin
        memrd = 1'b1; alusrcb = 2'b01; alucontrol = ALU_ADD;
        irwrite = memready; pcen = memready;
      end
      S_DECODE: begin
        alusrcb = 2'b11; alucontrol = ALU_ADD; signext = 1'b1;
      end
      S_MEMADR: begin
        alusrca = 1'b1; alusrcb = 2'b10; alucontrol = ALU_ADD; signext = 1'b1;
      end
      S_MEMRD:  begin memrd = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin regwrite = 1'b1; memtoreg = 1'b1; end
      S_MEMWR:  begin memwr = 1'b1; iord = 1'b1; end
      S_EXEC:   begin alusrca = 1'b1; alucontrol = fdec[2:0]; end
      S_ALUWB:  begin regwrite = 1'b1; regdst = 1'b1; end
      S_BRANCH: begin
        alusrca = 1'b1; alucontrol = ALU_SUB; pcsrc = 2'b01;
        pcen = zero ^ (op == OP_BNE);
      end
      S_IMMEX, S_IMMWB: begin
        alusrca = 1'b1; alusrcb = 2'b10; alucontrol = ALU_ADD;
        regwrite = (cur == S_IMMWB);
        case (op)
          OP_ORI:  alucontrol = ALU_OR;
          OP_LUI:  shiftl16 = 1'b1;
          default: signext = 1'b1;
        endcase
      end
      S_JUMP: begin
        pcsrc = 2'b10; pcen = 1'b1;
        regwrite = (op == OP_JAL); isjal = (op == OP_JAL);
      end
      S_JR:     begin pcsrc = 2'b11; pcen = 1'b1; end
      S_HALT:   halted = 1'b1;
      default:  halted = 1'b0;
    endcase
    // Reset kills every side effect in the same cycle it rises.
    if (reset) begin
      memrd = 1'b0; memwr = 1'b0; irwrite = 1'b0;
      pcen = 1'b0; regwrite = 1'b0; halted = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random and directed instruction streams against a per-instruction phase model
// built from each instruction class's architectural sequence.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, reset_nop;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       memrd, memwr, iord, irwrite, pcen, alusrca, signext, shiftl16;
  logic       regwrite, regdst, memtoreg, isjal, halted;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       n_memrd, n_memwr, n_iord, n_irwrite, n_pcen, n_alusrca, n_signext, n_shiftl16;
  logic       n_regwrite, n_regdst, n_memtoreg, n_isjal, n_halted;
  logic [1:0] n_pcsrc, n_alusrcb;
  logic [2:0] n_alucontrol;
  logic [3:0] n_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memrd(memrd), .memwr(memwr), .iord(iord), .irwrite(irwrite), .pcen(pcen),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .signext(signext), .shiftl16(shiftl16), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .isjal(isjal), .halted(halted), .state(state)
  );

  multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) u_nop (
    .clk(clk), .reset(reset_nop), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memrd(n_memrd), .memwr(n_memwr), .iord(n_iord), .irwrite(n_irwrite), .pcen(n_pcen),
    .pcsrc(n_pcsrc), .alusrca(n_alusrca), .alusrcb(n_alusrcb), .alucontrol(n_alucontrol),
    .signext(n_signext), .shiftl16(n_shiftl16), .regwrite(n_regwrite), .regdst(n_regdst),
    .memtoreg(n_memtoreg), .isjal(n_isjal), .halted(n_halted), .state(n_state)
  );

  // Enables packed as {memrd, memwr, irwrite, pcen, regwrite, halted}.
  logic [5:0] en;
  assign en = {memrd, memwr, irwrite, pcen, regwrite, halted};
  localparam logic [5:0] E_MRD = 6'b100000, E_MWR = 6'b010000, E_IR = 6'b001000;
  localparam logic [5:0] E_PC  = 6'b000100, E_RW  = 6'b000010, E_HLT = 6'b000001;

  localparam logic [5:0] OP_R   = 6'd0,  OP_LW  = 6'd35, OP_SW   = 6'd43, OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5,  OP_J   = 6'd2,  OP_JAL  = 6'd3,  OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9, OP_ORI = 6'd13, OP_LUI = 6'd15;
  localparam logic [5:0] F_ADD = 6'd32, F_JR = 6'd8;

  logic [5:0] op_tab[14]  = '{OP_R, OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
                              OP_ADDIU, OP_ORI, OP_LUI, OP_J, OP_JAL, 6'd63};
  logic [5:0] ill_tab[4]  = '{6'd63, 6'd16, 6'd32, 6'd10};
  logic [5:0] fn_tab[8]   = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd42, 6'd8};

  typedef struct {
    logic [3:0] st;
    logic [5:0] en;
    bit         mem;
    int         waits;
    int         reps;
    bit         ck_pc;
    logic [1:0] pc;
    bit         ck_alu;
    logic [2:0] alu;
    bit         ck_wb;
    logic [2:0] wb;     // {regdst, memtoreg, isjal}
    bit         ck_iord;
    logic       iord;
  } phase_t;

  phase_t plan[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {defined, alucontrol} of an R-type funct from the instruction set table.
  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'd32, 6'd33: return 4'b1010;
      6'd34, 6'd35: return 4'b1110;
      6'd36:        return 4'b1000;
      6'd37:        return 4'b1001;
      6'd42:        return 4'b1111;
      default:      return 4'b0000;
    endcase
  endfunction

  function automatic phase_t ph(input logic [3:0] st, input logic [5:0] e);
    phase_t p;
    p = '{default: 0};
    p.st = st; p.en = e; p.reps = 1;
    return p;
  endfunction

  // Architectural phase list of one instruction; memory phases carry their wait count.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int wf, input int wm);
    phase_t p;
    logic [3:0] ra;
    plan.delete();
    p = ph(4'd0, E_MRD | E_IR | E_PC); p.mem = 1; p.waits = wf;
    p.ck_pc = 1; p.pc = 2'b00; p.ck_alu = 1; p.alu = 3'b010; p.ck_iord = 1; p.iord = 0;
    plan.push_back(p);
    p = ph(4'd1, 6'd0); p.ck_alu = 1; p.alu = 3'b010; plan.push_back(p);
    ra = r_alu(f);
    if (o == OP_R && f == F_JR) begin
      p = ph(4'd12, E_PC); p.ck_pc = 1; p.pc = 2'b11; plan.push_back(p);
    end else if (o == OP_R) begin
      p = ph(4'd6, 6'd0); p.ck_alu = ra[3]; p.alu = ra[2:0]; plan.push_back(p);
      if (ra[3]) begin
        p = ph(4'd7, E_RW); p.ck_wb = 1; p.wb = 3'b100; plan.push_back(p);
      end
    end else if (o == OP_LW || o == OP_SW) begin
      p = ph(4'd2, 6'd0); p.ck_alu = 1; p.alu = 3'b010; plan.push_back(p);
      p = (o == OP_LW) ? ph(4'd3, E_MRD) : ph(4'd5, E_MWR);
      p.mem = 1; p.waits = wm; p.ck_iord = 1; p.iord = 1; plan.push_back(p);
      if (o == OP_LW) begin
        p = ph(4'd4, E_RW); p.ck_wb = 1; p.wb = 3'b010; plan.push_back(p);
      end
    end else if (o == OP_BEQ || o == OP_BNE) begin
      p = ph(4'd8, (z ^ (o == OP_BNE)) ? E_PC : 6'd0);
      p.ck_pc = 1; p.pc = 2'b01; p.ck_alu = 1; p.alu = 3'b110; plan.push_back(p);
    end else if (o == OP_ADDI || o == OP_ADDIU || o == OP_ORI || o == OP_LUI) begin
      p = ph(4'd9, 6'd0); p.ck_alu = 1; p.alu = (o == OP_ORI) ? 3'b001 : 3'b010;
      plan.push_back(p);
      p.st = 4'd10; p.en = E_RW; p.ck_wb = 1; p.wb = 3'b000; plan.push_back(p);
    end else if (o == OP_J || o == OP_JAL) begin
      p = ph(4'd11, (o == OP_JAL) ? (E_PC | E_RW) : E_PC); p.ck_pc = 1; p.pc = 2'b10;
      p.ck_wb = (o == OP_JAL); p.wb = 3'b001; plan.push_back(p);
    end
    if (plan[$].st == 4'd6 && !ra[3] || !(o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
        OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI, OP_J, OP_JAL})) begin
      p = ph(4'd13, E_HLT); p.reps = 3; plan.push_back(p);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset/en", 32'(en), 32'd0);
    check("reset/state", 32'(state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_plan(input string tag);
    int  n;
    bit  last;
    foreach (plan[i]) begin
      n = plan[i].mem ? plan[i].waits + 1 : plan[i].reps;
      for (int c = 0; c < n; c++) begin
        last = (c == n - 1);
        memready = plan[i].mem ? last : 1'($urandom);
        @(negedge clk);
        check({tag, "/state"}, 32'(state), 32'(plan[i].st));
        check({tag, "/en"}, 32'(en),
              32'((plan[i].mem && !last) ? (plan[i].en & (E_MRD | E_MWR)) : plan[i].en));
        if (plan[i].ck_pc && last) check({tag, "/pcsrc"}, 32'(pcsrc), 32'(plan[i].pc));
        if (plan[i].ck_alu) check({tag, "/alu"}, 32'(alucontrol), 32'(plan[i].alu));
        if (plan[i].ck_wb) check({tag, "/wbsel"}, 32'({regdst, memtoreg, isjal}),
                                 32'(plan[i].wb));
        if (plan[i].ck_iord) check({tag, "/iord"}, 32'(iord), 32'(plan[i].iord));
        @(posedge clk); #1;
      end
    end
    if (plan[$].st == 4'd13) do_reset();
  endtask

  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int wf, input int wm);
    op = o; funct = f; zero = z;
    build(o, f, z, wf, wm);
    run_plan(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] o, f;
    int sel;
    reset = 1'b1; reset_nop = 1'b1;
    op = 6'd0; funct = 6'd0; zero = 1'b0; memready = 1'b0;
    do_reset();

    run_instr("add",  OP_R,   F_ADD, 1'b0, 0, 0);
    run_instr("lw",   OP_LW,  6'd0,  1'b0, 2, 3);
    run_instr("beq1", OP_BEQ, 6'd0,  1'b1, 0, 0);
    run_instr("bne1", OP_BNE, 6'd0,  1'b1, 0, 0);
    run_instr("bne0", OP_BNE, 6'd0,  1'b0, 0, 0);
    run_instr("jal",  OP_JAL, 6'd0,  1'b0, 0, 0);
    run_instr("jr",   OP_R,   F_JR,  1'b0, 0, 0);
    run_instr("ill",  6'd63,  6'd0,  1'b0, 0, 0);

    // Both parameterisations side by side on an undefined opcode.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; reset_nop = 1'b0; op = 6'd63; memready = 1'b1;
    @(negedge clk); check("nop/s0", 32'(n_state), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("nop/s1", 32'(n_state), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("nop/s2", 32'(n_state), 32'd0);
    check("nop/halted", 32'(n_halted), 32'd0);
    check("halt/s2", 32'(state), 32'd13);
    check("halt/en", 32'(en), 32'(E_HLT));
    reset_nop = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Reset in the middle of a stalled store.
    op = OP_SW; memready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    memready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("swrst/pre_memwr", 32'(memwr), 32'd1);
    reset = 1'b1;
    #1;
    check("swrst/memwr", 32'(memwr), 32'd0);
    check("swrst/state", 32'(state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; memready = 1'b1;
    @(negedge clk);
    check("swrst/rel_state", 32'(state), 32'd0);
    check("swrst/rel_memrd", 32'(memrd), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("swrst/decode", 32'(state), 32'd1);
    @(posedge clk); #1;
    do_reset();

    for (int k = 0; k < 300; k++) begin
      o = op_tab[$urandom_range(0, 13)];
      if (o == 6'd63) o = ill_tab[$urandom_range(0, 3)];
      sel = $urandom_range(0, 9);
      f = (sel < 8) ? fn_tab[sel] : 6'($urandom);
      if (o != OP_R) f = 6'($urandom);
      run_instr("rnd", o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
